// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: state codes, ISA
// class and sub-op codes, datapath mux encodings and decode helpers.
package mc_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_FETCH    = 5'd0;
  localparam state_t S_DECODE   = 5'd1;
  localparam state_t S_MEM_ADDR = 5'd2;
  localparam state_t S_MEM_RD   = 5'd3;
  localparam state_t S_MEM_WR   = 5'd4;
  localparam state_t S_MEM_WB   = 5'd5;
  localparam state_t S_EXEC_I   = 5'd6;
  localparam state_t S_EXEC_R   = 5'd7;
  localparam state_t S_ALU_WB   = 5'd8;
  localparam state_t S_BRANCH   = 5'd9;
  localparam state_t S_JUMP     = 5'd10;
  localparam state_t S_LI       = 5'd11;
  localparam state_t S_LUI      = 5'd12;
  localparam state_t S_IMM_WB   = 5'd13;
  localparam state_t S_HALT     = 5'd14;
  localparam state_t S_TRAP     = 5'd15;

  localparam logic [1:0] CL_JMP = 2'b00;
  localparam logic [1:0] CL_REG = 2'b01;
  localparam logic [1:0] CL_BR  = 2'b10;
  localparam logic [1:0] CL_IMM = 2'b11;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LI  = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
  localparam logic [3:0] OP_LWI = 4'b1011;
  localparam logic [3:0] OP_SWI = 4'b1100;
  localparam logic [3:0] OP_LW  = 4'b1101;
  localparam logic [3:0] OP_SW  = 4'b1110;
  localparam logic [3:0] OP_ILL = 4'b1111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_PASS = 4'b0000;

  function automatic logic is_load(logic [3:0] sub);
    return (sub == OP_LWI) || (sub == OP_LW);
  endfunction

  function automatic logic is_mem(logic [3:0] sub);
    return is_load(sub) || (sub == OP_SWI) || (sub == OP_SW);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction class decode: instr -> state after DECODE
// (FETCH for NOOP) and state after MEM_ADDR (MEM_RD or MEM_WR).
module mc_decode
  import mc_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] instr,
  output state_t        dec_next,
  output state_t        mem_next
);

  logic [1:0] cls;
  logic [3:0] sub;
  logic       nop;
  logic       unused_bits;
  state_t     imm_next;

  assign cls = instr[IW-1:IW-2];
  assign sub = instr[IW-3:IW-6];
  assign nop = (cls == CL_JMP) && (sub == OP_NOP);
  assign unused_bits = ^instr[IW-7:0];

  always_comb begin
    imm_next = S_EXEC_I;
    if (sub == OP_LI)
      imm_next = S_LI;
    else if (sub == OP_LUI)
      imm_next = S_LUI;
    else if (is_mem(sub))
      imm_next = S_MEM_ADDR;
    else if (sub == OP_ILL)
      imm_next = S_TRAP;
  end

  always_comb begin
    dec_next = S_TRAP;
    unique case (1'b1)
      nop:                     dec_next = S_FETCH;
      (cls == CL_JMP) && !nop: dec_next = S_JUMP;
      cls == CL_REG:           dec_next = S_EXEC_R;
      cls == CL_BR:            dec_next = S_BRANCH;
      cls == CL_IMM:           dec_next = imm_next;
      default:                 dec_next = S_TRAP;
    endcase
  end

  assign mem_next = is_load(sub) ? S_MEM_RD : S_MEM_WR;

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle control unit with memory handshake, halt/run and trap.
// in: clk, reset, instr_in, mem_ready, run. out: state, datapath
// controls, PCSource, ALUSrcB, ALUOp, trap, busy.
module mc_ctrl_hs
  import mc_pkg::*;
#(
  parameter int IW      = 32,
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IW-1:0]      instr_in,
  input  logic               mem_ready,
  input  logic               run,
  output logic [STATE_W-1:0] state,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               BranchType,
  output logic               LUI,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               trap,
  output logic               busy
);

  state_t     st;
  state_t     nxt;
  state_t     fe;
  state_t     dec_next;
  state_t     mem_next;
  logic [3:0] sub;
  logic [3:0] alu_op;

  assign sub = instr_in[IW-3:IW-6];

  mc_decode #(.IW(IW)) u_dec (
    .instr    (instr_in),
    .dec_next (dec_next),
    .mem_next (mem_next)
  );

  // Every return to FETCH passes through the run check, so a halt
  // request parks before the next fetch starts.
  assign fe = run ? S_FETCH : S_HALT;

  always_comb begin
    nxt = st;
    case (st)
      S_FETCH:    if (mem_ready) nxt = S_DECODE;
      S_DECODE:   nxt = (dec_next == S_FETCH) ? fe : dec_next;
      S_MEM_ADDR: nxt = mem_next;
      S_MEM_RD:   if (mem_ready) nxt = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) nxt = fe;
      S_MEM_WB:   nxt = fe;
      S_EXEC_I:   nxt = S_ALU_WB;
      S_EXEC_R:   nxt = S_ALU_WB;
      S_ALU_WB:   nxt = fe;
      S_BRANCH:   nxt = fe;
      S_JUMP:     nxt = fe;
      S_LI:       nxt = S_IMM_WB;
      S_LUI:      nxt = S_IMM_WB;
      S_IMM_WB:   nxt = fe;
      S_HALT:     if (run) nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      st <= S_FETCH;
    else
      st <= nxt;
  end

  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    BranchType = 1'b0;
    LUI        = 1'b0;
    PCSource   = PCS_ALU;
    ALUSrcB    = SRCB_REG;
    alu_op     = ALU_PASS;
    trap       = 1'b0;
    busy       = 1'b1;
    case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        alu_op  = ALU_ADD;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_ZEXT;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
        alu_op  = ALU_ADD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
        alu_op  = sub;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        alu_op  = sub;
      end
      S_ALU_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        PCWrite    = 1'b1;
        BranchType = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JMP;
      end
      S_LI: begin
        ALUSrcB = SRCB_ZEXT;
        alu_op  = sub;
      end
      S_LUI: begin
        ALUSrcB = SRCB_ZEXT;
        alu_op  = sub;
        LUI     = 1'b1;
      end
      S_IMM_WB: RegWrite = 1'b1;
      S_HALT: busy = 1'b0;
      S_TRAP: begin
        trap = 1'b1;
        busy = 1'b0;
      end
      default: ;
    endcase
  end

  assign ALUOp = ALUOP_W'(alu_op);
  assign state = STATE_W'(st);

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: expected state/control vectors are
// queued per cycle and compared at the falling edge.
module tb_mc_ctrl_hs;
  import mc_pkg::*;

  typedef struct packed {
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       srca;
    logic       rw;
    logic       bt;
    logic       lui;
    logic [1:0] pcs;
    logic [1:0] srcb;
    logic [3:0] aop;
    logic       trp;
    logic       bsy;
  } ctl_t;

  typedef struct packed {
    logic [4:0] st;
    ctl_t       ctl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic        run;
  logic [4:0]  state;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, ALUSrcA, RegWrite, BranchType, LUI;
  logic [1:0]  PCSource, ALUSrcB;
  logic [3:0]  ALUOp;
  logic        trap, busy;

  int   checks = 0;
  int   failures = 0;
  int   pcw_cnt = 0;
  int   irw_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mc_ctrl_hs dut (
    .clk        (clk),
    .reset      (reset),
    .instr_in   (instr_in),
    .mem_ready  (mem_ready),
    .run        (run),
    .state      (state),
    .PCWrite    (PCWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .RegWrite   (RegWrite),
    .BranchType (BranchType),
    .LUI        (LUI),
    .PCSource   (PCSource),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .trap       (trap),
    .busy       (busy)
  );

  function automatic ctl_t exp_ctl(logic [4:0] s, logic rdy,
                                   logic [3:0] sub);
    ctl_t c;
    c = '0;
    c.bsy = 1'b1;
    case (s)
      S_FETCH: begin
        c.mrd = 1'b1; c.srcb = 2'b01; c.aop = 4'b0010;
        c.pcw = rdy; c.irw = rdy;
      end
      S_DECODE:   c.srcb = 2'b11;
      S_MEM_ADDR: begin
        c.srca = 1'b1; c.srcb = 2'b10; c.aop = 4'b0010;
      end
      S_MEM_RD:   begin c.mrd = 1'b1; c.iord = 1'b1; end
      S_MEM_WR:   begin c.mwr = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:   begin c.rw = 1'b1; c.m2r = 1'b1; end
      S_EXEC_I:   begin c.srca = 1'b1; c.srcb = 2'b10; c.aop = sub; end
      S_EXEC_R:   begin c.srca = 1'b1; c.aop = sub; end
      S_ALU_WB:   c.rw = 1'b1;
      S_BRANCH:   begin c.pcw = 1'b1; c.bt = 1'b1; end
      S_JUMP:     begin c.pcw = 1'b1; c.pcs = 2'b10; end
      S_LI:       begin c.srcb = 2'b11; c.aop = sub; end
      S_LUI:      begin c.srcb = 2'b11; c.aop = sub; c.lui = 1'b1; end
      S_IMM_WB:   c.rw = 1'b1;
      S_HALT:     c.bsy = 1'b0;
      S_TRAP:     begin c.bsy = 1'b0; c.trp = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] mk(logic [1:0] cls, logic [3:0] sub);
    return {cls, sub, 26'h155_5555};
  endfunction

  task automatic cyc(input logic [4:0] s, input logic rdy,
                     input string tag);
    exp_t e;
    ctl_t o;
    mem_ready = rdy;
    e.st = s;
    e.ctl = exp_ctl(s, rdy, instr_in[29:26]);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    o = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
         ALUSrcA, RegWrite, BranchType, LUI, PCSource, ALUSrcB,
         ALUOp, trap, busy};
    checks++;
    assert (state === e.st) else begin
      failures++;
      $error("FAIL %s state got %0d expected %0d", tag, state, e.st);
    end
    checks++;
    assert (o === e.ctl) else begin
      failures++;
      $error("FAIL %s ctl got %h expected %h", tag, o, e.ctl);
    end
    pcw_cnt += int'(PCWrite);
    irw_cnt += int'(IRWrite);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b1;
    mem_ready = 1'b1;
    instr_in = '0;
    @(posedge clk);
    #1;
    cyc(S_FETCH, 1'b1, "reset");
    reset = 1'b0;

    instr_in = mk(CL_IMM, 4'b0010);
    pcw_cnt = 0;
    cyc(S_FETCH, 1'b1, "addi_f");
    cyc(S_DECODE, 1'b1, "addi_d");
    cyc(S_EXEC_I, 1'b1, "addi_x");
    cyc(S_ALU_WB, 1'b1, "addi_wb");
    checks++;
    assert (pcw_cnt === 1) else begin
      failures++;
      $error("FAIL addi_pcw got %0d expected 1", pcw_cnt);
    end

    instr_in = mk(CL_IMM, OP_LW);
    cyc(S_FETCH, 1'b1, "lw_f");
    cyc(S_DECODE, 1'b1, "lw_d");
    cyc(S_MEM_ADDR, 1'b1, "lw_a");
    cyc(S_MEM_RD, 1'b0, "lw_st1");
    cyc(S_MEM_RD, 1'b0, "lw_st2");
    cyc(S_MEM_RD, 1'b0, "lw_st3");
    cyc(S_MEM_RD, 1'b1, "lw_rd");
    cyc(S_MEM_WB, 1'b1, "lw_wb");

    instr_in = mk(CL_IMM, OP_SW);
    cyc(S_FETCH, 1'b1, "sw_f");
    cyc(S_DECODE, 1'b1, "sw_d");
    cyc(S_MEM_ADDR, 1'b1, "sw_a");
    cyc(S_MEM_WR, 1'b0, "sw_st");
    cyc(S_MEM_WR, 1'b1, "sw_wr");

    instr_in = mk(CL_IMM, OP_SWI);
    cyc(S_FETCH, 1'b1, "swi_f");
    cyc(S_DECODE, 1'b1, "swi_d");
    cyc(S_MEM_ADDR, 1'b1, "swi_a");
    cyc(S_MEM_WR, 1'b1, "swi_wr");

    instr_in = mk(CL_IMM, OP_LI);
    cyc(S_FETCH, 1'b1, "li_f");
    cyc(S_DECODE, 1'b1, "li_d");
    cyc(S_LI, 1'b1, "li_x");
    cyc(S_IMM_WB, 1'b1, "li_wb");

    instr_in = mk(CL_IMM, OP_LUI);
    cyc(S_FETCH, 1'b1, "lui_f");
    cyc(S_DECODE, 1'b1, "lui_d");
    cyc(S_LUI, 1'b1, "lui_x");
    cyc(S_IMM_WB, 1'b1, "lui_wb");

    instr_in = mk(CL_BR, 4'b0000);
    cyc(S_FETCH, 1'b1, "br_f");
    cyc(S_DECODE, 1'b1, "br_d");
    cyc(S_BRANCH, 1'b1, "br_x");

    instr_in = mk(CL_JMP, 4'b0011);
    cyc(S_FETCH, 1'b1, "j_f");
    cyc(S_DECODE, 1'b1, "j_d");
    cyc(S_JUMP, 1'b1, "j_x");

    instr_in = 32'h0;
    cyc(S_FETCH, 1'b1, "nop_f");
    cyc(S_DECODE, 1'b1, "nop_d");

    instr_in = mk(CL_REG, 4'b0110);
    cyc(S_FETCH, 1'b1, "r_f");
    cyc(S_DECODE, 1'b1, "r_d");
    run = 1'b0;
    cyc(S_EXEC_R, 1'b1, "r_x");
    cyc(S_ALU_WB, 1'b1, "r_wb");
    cyc(S_HALT, 1'b1, "halt1");
    cyc(S_HALT, 1'b0, "halt2");
    run = 1'b1;
    cyc(S_HALT, 1'b1, "halt3");

    instr_in = 32'h0;
    irw_cnt = 0;
    cyc(S_FETCH, 1'b0, "fst1");
    cyc(S_FETCH, 1'b0, "fst2");
    cyc(S_FETCH, 1'b1, "fst3");
    cyc(S_DECODE, 1'b1, "fst_d");
    checks++;
    assert (irw_cnt === 1) else begin
      failures++;
      $error("FAIL fetch_irw got %0d expected 1", irw_cnt);
    end

    instr_in = mk(CL_IMM, OP_LWI);
    cyc(S_FETCH, 1'b1, "rst_f");
    cyc(S_DECODE, 1'b1, "rst_d");
    cyc(S_MEM_ADDR, 1'b1, "rst_a");
    cyc(S_MEM_RD, 1'b0, "rst_rd1");
    reset = 1'b1;
    cyc(S_MEM_RD, 1'b0, "rst_rd2");
    reset = 1'b0;
    cyc(S_FETCH, 1'b0, "rst_post");

    instr_in = mk(CL_IMM, OP_ILL);
    cyc(S_FETCH, 1'b1, "ill_f");
    cyc(S_DECODE, 1'b1, "ill_d");
    for (int i = 0; i < 20; i++)
      cyc(S_TRAP, 1'(i % 2), $sformatf("trap%0d", i));
    reset = 1'b1;
    cyc(S_TRAP, 1'b1, "trap_rst");
    reset = 1'b0;
    cyc(S_FETCH, 1'b0, "trap_exit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
